nice_rr_grant_sequencer: RTL and testbench
==========================================

// Module: nice_rr_grant_sequencer
// PURPOSE
//  Round-robin scheduler that shares one downstream resource (bus port, table, engine) among NUM_REQ requesters.
//  Issues one registered one-hot grant at a time; the grant retires on a resource beat.
//  Next grant follows back-to-back, with no idle bubble.
//  Hardware counterpart of the patterns iterator: walks requesters in circular order. Starvation-free.
// PARAMETERS
//  NUM_REQ   4   number of requesters, >=1
//  MAX_LOCK  8   max beats one locked grant may hold (used only with NICE_RR_SEQ_LOCK_EN), >=1
//  IDW       $clog2(NUM_REQ) or 1, whichever is larger   width of gnt_id_o (localparam)
// PORTS
//  clk          in   1        single clock; all state on posedge
//  rst          in   1        synchronous, active-high reset
//  req_i        in   NUM_REQ  request per requester; level, held until served or withdrawn
//  lock_i       in   NUM_REQ  keep grant after current beat (ignored unless lock feature compiled)
//  rsrc_ready_i in   1        resource accepts a beat this cycle
//  gnt_o        out  NUM_REQ  one-hot grant, registered
//  gnt_id_o     out  IDW      binary index of granted requester
//  gnt_valid_o  out  1        |gnt_o
//  beat_o       out  1        gnt_valid_o & rsrc_ready_i (combinational strobe)
// BEHAVIOUR
//  Reset values:
//   - gnt_o=0, gnt_id_o=0, gnt_valid_o=0, state=ARB_IDLE, lock_cnt=0.
//   - ptr=NUM_REQ-1, so index 0 has first priority.
//  Pick rule: winner = first set req_i bit scanning ptr+1, ptr+2, ... modulo NUM_REQ (wraps at NUM_REQ-1 -> 0).
//  ARB_IDLE:
//   - any req_i -> ARB_GRANT next cycle with gnt_o=onehot(winner).
//   - Request-to-grant latency = 1 cycle.
//  ARB_GRANT, grant held stable while req_i[id]=1 and rsrc_ready_i=0. No timeout.
//  Beat (gnt_valid_o & rsrc_ready_i):
//   - ptr<=id; re-pick in the same cycle.
//   - The new grant is visible next cycle: back-to-back; a sole requester is re-granted every cycle.
//   - No other request -> ARB_IDLE, gnt_o=0.
//  Withdraw (req_i[id]=0 without beat):
//   - Treated as served: ptr<=id, re-pick as for a beat.
//   - beat_o stays 0.
//  Simultaneous beat and withdraw in one cycle -> counts as a beat.
//  Fairness: a continuously asserted request is granted within NUM_REQ-1 foreign grants.
//  gnt_o is never multi-hot; gnt_id_o is always consistent with gnt_o (0 when idle).
//  rst mid-grant: outputs clear at that edge; the in-flight grant is dropped and no ptr update occurs.
//  NUM_REQ=1: pick is trivial; ptr is constant 0.
// CONFIGURATION
//  `NICE_RR_SEQ_LOCK_EN defined:
//   - Beat with lock_i[id]=1 and lock_cnt<MAX_LOCK-1 -> state ARB_LOCKED, same grant, lock_cnt++, ptr unchanged.
//   - In ARB_LOCKED the pick is suppressed.
//   - A beat with lock_i[id]=0 releases the grant.
//   - A beat with lock_cnt==MAX_LOCK-1 force-releases the grant.
//   - Withdraw also releases.
//   - Release behaves like a normal beat and clears lock_cnt.
//   - Fairness bound becomes (NUM_REQ-1)*MAX_LOCK beats.
//  Macro undefined: lock_i unused, ARB_LOCKED unreachable, lock_cnt not synthesised.
// STRUCTURE
//  Package nice_arb_pkg holds:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_LOCKED} arb_state_e;
//   - function rr_pick(req, ptr), returning {found, index}.
//  Sub-module nice_rr_pick: combinational rotate + priority encode + rotate back, parameterised by NUM_REQ.
//   - Used once here; reused by later arbiters.
//  Top holds state register, ptr, grant registers, lock_cnt.
// TESTING
//  T1 reset: rst=1 for 3 cycles with req_i=4'hF -> gnt_o=0, gnt_valid_o=0; after release gnt_o=4'b0001 one cycle later.
//  T2 rotation: req_i=4'hF, rsrc_ready_i=1 constant -> gnt_id_o sequence 0,1,2,3,0,1 on consecutive cycles, no idle cycle.
//  T3 stall+withdraw: req_i=4'b0110, rsrc_ready_i=0.
//   - Expect gnt_o=0010 held.
//   - Drop req_i[1] -> next cycle gnt_o=0100, beat_o never 1.
//  T4 sparse wrap: ptr=2 after grant to 2, then only req_i[0] and req_i[1] asserted -> grant 0 first, then 1.
//  T5 lock (macro on, MAX_LOCK=4): req_i=4'b0011, lock_i[0]=1, ready=1 -> requester 0 gets exactly 4 beats, then gnt_id_o=1.
//  T6 reset mid-lock: assert rst during 2nd locked beat -> gnt_o=0 next edge; after release grant goes to index 0 (ptr reset), lock_cnt=0.

Source files
------------

// File: rtl/nice_arb_pkg.sv
// nice_arb_pkg: shared arbiter state encoding and the round-robin pick function.
package nice_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_LOCKED} arb_state_e;
  localparam int MAX_REQ = 32;
  localparam int MAX_IDW = 5;
  typedef struct packed {
    logic found;
    logic [MAX_IDW-1:0] idx;
  } pick_t;
  // Rotate so that ptr+1 sits at bit 0, take the lowest set bit, rotate the index back.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req, input logic [MAX_IDW-1:0] ptr, input int n);
    logic [MAX_REQ-1:0] rot;
    int s;
    int e;
    rot = '0;
    e = 0;
    s = (int'(ptr) + 1) % n;
    for (int i = 0; i < MAX_REQ; i++) if (i < n) rot[MAX_IDW'(i)] = req[MAX_IDW'((s + i) % n)];
    for (int i = MAX_REQ - 1; i >= 0; i--) if (rot[MAX_IDW'(i)]) e = i;
    rr_pick.found = |rot;
    rr_pick.idx = MAX_IDW'((e + s) % n);
  endfunction
endpackage

// File: rtl/nice_rr_pick.sv
// nice_rr_pick: combinational round-robin winner search starting after ptr (NUM_REQ <= 32).
module nice_rr_pick import nice_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int IDW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               found,
  output logic [IDW-1:0]     idx
);
  pick_t p;
  always_comb p = rr_pick(MAX_REQ'(req), MAX_IDW'(ptr), NUM_REQ);
  assign found = p.found;
  assign idx = IDW'(p.idx);
endmodule

// File: rtl/nice_rr_grant_sequencer.sv
// nice_rr_grant_sequencer: round-robin one-hot grant sequencer, back-to-back grants on resource beats.
// Optional multi-beat grant locking is compiled in with NICE_RR_SEQ_LOCK_EN.
module nice_rr_grant_sequencer import nice_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int MAX_LOCK = 8,
  localparam int IDW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] lock_i,
  input  logic               rsrc_ready_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_id_o,
  output logic               gnt_valid_o,
  output logic               beat_o
);
  arb_state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_d, win;
  logic [NUM_REQ-1:0] gnt_d;
  logic found, done, lock_go;
`ifdef NICE_RR_SEQ_LOCK_EN
  localparam int CW = MAX_LOCK > 1 ? $clog2(MAX_LOCK) : 1;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  assign lock_go = beat_o & req_i[gnt_id_o] & lock_i[gnt_id_o] & (lock_cnt_q < CW'(MAX_LOCK - 1));
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign lock_go = 1'b0;
`endif
  assign gnt_valid_o = |gnt_o;
  assign beat_o = gnt_valid_o & rsrc_ready_i;
  // A withdraw retires the grant like a beat, so the search restarts after the retiring index.
  assign done = beat_o | (gnt_valid_o & ~req_i[gnt_id_o]);

  nice_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req_i),
    .ptr(done ? gnt_id_o : ptr_q),
    .found(found),
    .idx(win)
  );

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_o;
    id_d = gnt_id_o;
`ifdef NICE_RR_SEQ_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    if (lock_go) begin
      state_d = ARB_LOCKED;
`ifdef NICE_RR_SEQ_LOCK_EN
      lock_cnt_d = lock_cnt_q + 1'b1;
`endif
    end else if (done || state_q == ARB_IDLE) begin
      ptr_d = done ? gnt_id_o : ptr_q;
      state_d = found ? ARB_GRANT : ARB_IDLE;
      gnt_d = found ? NUM_REQ'(1) << win : '0;
      id_d = found ? win : '0;
`ifdef NICE_RR_SEQ_LOCK_EN
      lock_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q <= IDW'(NUM_REQ - 1);
      gnt_o <= '0;
      gnt_id_o <= '0;
`ifdef NICE_RR_SEQ_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_o <= gnt_d;
      gnt_id_o <= id_d;
`ifdef NICE_RR_SEQ_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_nice_rr_grant_sequencer.sv
// tb_nice_rr_grant_sequencer: directed stimulus with a queued scoreboard checked by a grant monitor.
module tb_nice_rr_grant_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req, lock, gnt;
  logic rdy;
  logic [1:0] gid;
  logic gval, beat;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic beat;
    string name;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  nice_rr_grant_sequencer #(.NUM_REQ(4), .MAX_LOCK(4)) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .lock_i(lock),
    .rsrc_ready_i(rdy),
    .gnt_o(gnt),
    .gnt_id_o(gid),
    .gnt_valid_o(gval),
    .beat_o(beat)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle; v/id/b describe what the DUT must show during this cycle.
  task automatic cyc(input string name, input logic [3:0] r, input logic rd, input logic v, input int id, input logic b);
    exp_t e;
    req = r;
    rdy = rd;
    if (v) begin
      e.gnt = 4'b0001 << id;
      e.id = 2'(id);
      e.beat = b;
      e.name = name;
      q.push_back(e);
    end else begin
      chk({name, "_gnt"}, 32'(gnt), 32'd0);
      chk({name, "_id"}, 32'(gid), 32'd0);
      chk({name, "_valid"}, 32'(gval), 32'd0);
      chk({name, "_beat"}, 32'(beat), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (gval === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_grant: got gnt %b expected none", gnt);
      end else begin
        e = q.pop_front();
        chk({e.name, "_gnt"}, 32'(gnt), 32'(e.gnt));
        chk({e.name, "_id"}, 32'(gid), 32'(e.id));
        chk({e.name, "_beat"}, 32'(beat), 32'(e.beat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = '0;
    rdy = 1'b0;
    lock = '0;
    @(posedge clk);
    #1;
    repeat (3) cyc("t1_rst", 4'hF, 1'b0, 1'b0, 0, 1'b0);
    rst = 1'b0;
    cyc("t1_rel", 4'hF, 1'b0, 1'b0, 0, 1'b0);
    cyc("t1_first", 4'hF, 1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 8; i++) cyc("t2_rot", 4'hF, 1'b1, 1'b1, i % 4, 1'b1);
    cyc("t3_beatwd", 4'b0110, 1'b1, 1'b1, 0, 1'b1);
    repeat (3) cyc("t3_stall", 4'b0110, 1'b0, 1'b1, 1, 1'b0);
    cyc("t3_wd", 4'b0100, 1'b0, 1'b1, 1, 1'b0);
    cyc("t3_next", 4'b0100, 1'b0, 1'b1, 2, 1'b0);
    cyc("t4_beat2", 4'b0011, 1'b1, 1'b1, 2, 1'b1);
    cyc("t4_wrap0", 4'b0011, 1'b1, 1'b1, 0, 1'b1);
    cyc("t4_then1", 4'b0011, 1'b1, 1'b1, 1, 1'b1);
    cyc("t4_wrap0b", 4'b0000, 1'b1, 1'b1, 0, 1'b1);
    cyc("t4_idle", 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    cyc("solo_req", 4'b1000, 1'b0, 1'b0, 0, 1'b0);
    repeat (2) cyc("solo", 4'b1000, 1'b1, 1'b1, 3, 1'b1);
    cyc("solo_last", 4'b0000, 1'b1, 1'b1, 3, 1'b1);
    cyc("solo_idle", 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    cyc("wd_req", 4'b0100, 1'b0, 1'b0, 0, 1'b0);
    cyc("wd_drop", 4'b0000, 1'b0, 1'b1, 2, 1'b0);
    cyc("wd_idle", 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    cyc("mr_req", 4'b0010, 1'b0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    cyc("mr_hold", 4'b1010, 1'b0, 1'b1, 1, 1'b0);
    rst = 1'b0;
    cyc("mr_clr", 4'b1010, 1'b0, 1'b0, 0, 1'b0);
    cyc("mr_ptr", 4'b1010, 1'b0, 1'b1, 1, 1'b0);
    cyc("mr_wd", 4'b0000, 1'b0, 1'b1, 1, 1'b0);
    cyc("mr_idle", 4'b0000, 1'b0, 1'b0, 0, 1'b0);
`ifdef NICE_RR_SEQ_LOCK_EN
    lock = 4'b0001;
    cyc("t5_req", 4'b0011, 1'b1, 1'b0, 0, 1'b0);
    repeat (4) cyc("t5_lock", 4'b0011, 1'b1, 1'b1, 0, 1'b1);
    cyc("t5_next", 4'b0011, 1'b1, 1'b1, 1, 1'b1);
    cyc("t5_wd", 4'b0000, 1'b0, 1'b1, 0, 1'b0);
    cyc("t5_idle", 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    cyc("t6_req", 4'b0001, 1'b1, 1'b0, 0, 1'b0);
    cyc("t6_b1", 4'b0001, 1'b1, 1'b1, 0, 1'b1);
    rst = 1'b1;
    cyc("t6_b2", 4'b0011, 1'b1, 1'b1, 0, 1'b1);
    rst = 1'b0;
    cyc("t6_clr", 4'b0011, 1'b1, 1'b0, 0, 1'b0);
    repeat (4) cyc("t6_lock", 4'b0011, 1'b1, 1'b1, 0, 1'b1);
    cyc("t6_next", 4'b0011, 1'b1, 1'b1, 1, 1'b1);
    cyc("t6_wd", 4'b0000, 1'b0, 1'b1, 0, 1'b0);
    cyc("t6_idle", 4'b0000, 1'b0, 1'b0, 0, 1'b0);
`endif
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
